// File: rtl/ess_pkg.sv
// Shared constants and state encoding for the host command path.
package ess_pkg;

  localparam logic [7:0] SYNC_DEFAULT        = 8'hA5;
  localparam int         FRAME_PAYLOAD_BYTES = 4;

  typedef enum logic [1:0] {
    FR_HUNT    = 2'd0,
    FR_PAYLOAD = 2'd1,
    FR_CHECK   = 2'd2,
    FR_HOLD    = 2'd3
  } fr_state_e;

endpackage

// File: rtl/tick_timeout.sv
// Counts timebase ticks while enabled; expire pulses on the tick that reaches
// TIMEOUT_TICKS. A clear in the same cycle as a tick wins.
module tick_timeout #(
  parameter int unsigned TIMEOUT_TICKS = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic expire
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_TICKS - 1);

  logic [7:0] cnt_q, cnt_d;

  assign expire = en && tick && !clr && (cnt_q == LAST_COUNT);

  // Disabled counts as cleared, so every entry into the enabled region starts at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire || !en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_framer.sv
// Framed command parser: hunts for SYNC, collects a 4-byte payload, verifies
// the XOR checksum and presents the command on a valid/ready handshake.
module cmd_framer
  import ess_pkg::*;
#(
  parameter logic [7:0]  SYNC          = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_TICKS = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tick,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_read,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_data,
  output logic        err_chk,
  output logic        err_timeout,
  output logic [15:0] frames_ok,
  output logic [7:0]  frames_bad
);

  localparam logic [1:0] LAST_IDX = 2'(FRAME_PAYLOAD_BYTES - 1);

  fr_state_e   state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        err_chk_q, err_chk_d;
  logic        err_to_q, err_to_d;
  logic [15:0] ok_q, ok_d;
  logic [7:0]  bad_q, bad_d;
  logic        bad_inc;
  logic        to_en;
  logic        to_expire;

  // HOLD never pops, which lets the FIFO fill and backpressure the UART side.
  assign fifo_read = !fifo_empty && (state_q != FR_HOLD);
  assign to_en     = (state_q == FR_PAYLOAD) || (state_q == FR_CHECK);

  tick_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clr    (fifo_read),
    .en     (to_en),
    .tick   (tick),
    .expire (to_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    shift_d     = shift_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    ok_d        = ok_q;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;
    bad_inc     = 1'b0;

    case (state_q)
      FR_HUNT: begin
        if (fifo_read && (fifo_data == SYNC)) begin
          state_d = FR_PAYLOAD;
          idx_d   = '0;
          chk_d   = '0;
        end
      end
      FR_PAYLOAD: begin
        if (fifo_read) begin
          shift_d = {shift_q[23:0], fifo_data};
          chk_d   = chk_q ^ fifo_data;
          idx_d   = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            state_d = FR_CHECK;
          end
        end else if (to_expire) begin
          state_d  = FR_HUNT;
          err_to_d = 1'b1;
          bad_inc  = 1'b1;
        end
      end
      FR_CHECK: begin
        if (fifo_read) begin
          if (fifo_data == chk_q) begin
            cmd_data_d  = shift_q;
            cmd_valid_d = 1'b1;
            ok_d        = ok_q + 16'd1;
            state_d     = FR_HOLD;
          end else begin
            err_chk_d = 1'b1;
            bad_inc   = 1'b1;
            state_d   = FR_HUNT;
          end
        end else if (to_expire) begin
          state_d  = FR_HUNT;
          err_to_d = 1'b1;
          bad_inc  = 1'b1;
        end
      end
      FR_HOLD: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = FR_HUNT;
        end
      end
      default: state_d = FR_HUNT;
    endcase

    bad_d = (bad_inc && (bad_q != 8'hFF)) ? bad_q + 8'd1 : bad_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FR_HUNT;
      idx_q       <= '0;
      chk_q       <= '0;
      shift_q     <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
      ok_q        <= '0;
      bad_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      shift_q     <= shift_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      err_chk_q   <= err_chk_d;
      err_to_q    <= err_to_d;
      ok_q        <= ok_d;
      bad_q       <= bad_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_data    = cmd_data_q;
  assign err_chk     = err_chk_q;
  assign err_timeout = err_to_q;
  assign frames_ok   = ok_q;
  assign frames_bad  = bad_q;

endmodule

// File: tb/tb_cmd_framer.sv
// Scoreboard bench for cmd_framer: byte streams are scanned frame-by-frame by a
// stream-level model; a monitor compares every handshaken command in order.
module tb_cmd_framer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tick = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_read;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_data;
  logic        err_chk;
  logic        err_timeout;
  logic [15:0] frames_ok;
  logic [7:0]  frames_bad;

  always #5 clk = ~clk;

  cmd_framer #(
    .SYNC          (8'hA5),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tick        (tick),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read   (fifo_read),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .frames_ok   (frames_ok),
    .frames_bad  (frames_bad)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned fifo_q[$];
  byte unsigned batch[$];
  logic [31:0]  exp_q[$];

  int ok_exp = 0, bad_exp = 0, chk_err_exp = 0, to_exp = 0;
  int chk_seen = 0, to_seen = 0;
  int stall_mode = 0;
  int ready_mode = 0;
  logic rd_sampled = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void bad_bump();
    if (bad_exp < 255) bad_exp++;
  endfunction

  // Stream-level reference: find SYNC, take the next five bytes as a frame.
  function automatic void model_and_send();
    int i = 0;
    logic [7:0] x;
    while (i < batch.size()) begin
      if (batch[i] != 8'hA5) begin
        i++;
      end else begin
        if (i + 5 >= batch.size()) break;
        x = batch[i+1] ^ batch[i+2] ^ batch[i+3] ^ batch[i+4];
        if (x == batch[i+5]) begin
          exp_q.push_back({batch[i+1], batch[i+2], batch[i+3], batch[i+4]});
          ok_exp++;
        end else begin
          chk_err_exp++;
          bad_bump();
        end
        i += 6;
      end
    end
    foreach (batch[k]) fifo_q.push_back(batch[k]);
    batch.delete();
  endfunction

  function automatic void add_frame(input logic [31:0] p, input bit corrupt);
    logic [7:0] c;
    c = p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
    if (corrupt) c = c ^ 8'($urandom_range(1, 255));
    batch.push_back(8'hA5);
    batch.push_back(p[31:24]);
    batch.push_back(p[23:16]);
    batch.push_back(p[15:8]);
    batch.push_back(p[7:0]);
    batch.push_back(c);
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
    return b;
  endfunction

  function automatic logic [7:0] rand_garbage();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  // FIFO model: pops what the DUT read at the last edge, then presents the head.
  initial begin
    logic stall;
    forever begin
      @(posedge clk);
      if (rd_sampled && fifo_q.size() > 0) void'(fifo_q.pop_front());
      #1;
      stall = (stall_mode == 1) && ($urandom_range(0, 3) == 0);
      fifo_empty = (fifo_q.size() == 0) || stall;
      fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       cmd_ready = 1'b0;
        1:       cmd_ready = 1'b1;
        default: cmd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold stability and pulse widths.
  initial begin
    logic        prev_valid = 1'b0, prev_hs = 1'b0, prev_chk = 1'b0, prev_to = 1'b0;
    logic [31:0] prev_data = '0;
    forever begin
      @(negedge clk);
      rd_sampled = fifo_read;
      if (resetn) begin
        if (cmd_valid) begin
          check("no_read_in_hold", {63'd0, fifo_read}, 64'd0);
          if (prev_valid && !prev_hs) check("hold_stable", {32'd0, cmd_data}, {32'd0, prev_data});
        end
        if (cmd_valid && cmd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got %08h, expected none", cmd_data);
          end else begin
            check("cmd_data", {32'd0, cmd_data}, {32'd0, exp_q.pop_front()});
          end
        end
        if (err_chk) begin
          chk_seen++;
          check("err_chk_width", {63'd0, prev_chk}, 64'd0);
        end
        if (err_timeout) begin
          to_seen++;
          check("err_timeout_width", {63'd0, prev_to}, 64'd0);
        end
        prev_valid = cmd_valid;
        prev_hs    = cmd_valid && cmd_ready;
        prev_chk   = err_chk;
        prev_to    = err_timeout;
        prev_data  = cmd_data;
      end else begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_chk   = 1'b0;
        prev_to    = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    cycles(1);
  endtask

  task automatic drain_and_check(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || cmd_valid) && n < 3000) begin
      cycles(1);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got pending=%0d, expected 0", name, exp_q.size());
      exp_q.delete();
      fifo_q.delete();
    end
    cycles(3);
    check({name, "_frames_ok"}, {48'd0, frames_ok}, 64'(16'(ok_exp)));
    check({name, "_frames_bad"}, {56'd0, frames_bad}, 64'(bad_exp));
    check({name, "_err_chk_cnt"}, 64'(chk_seen), 64'(chk_err_exp));
    check({name, "_err_to_cnt"}, 64'(to_seen), 64'(to_exp));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, {63'd0, cmd_valid}, 64'd0);
    check({name, "_data"}, {32'd0, cmd_data}, 64'd0);
    check({name, "_ok"}, {48'd0, frames_ok}, 64'd0);
    check({name, "_bad"}, {56'd0, frames_bad}, 64'd0);
    check({name, "_errs"}, {62'd0, err_chk, err_timeout}, 64'd0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    ok_exp = 0; bad_exp = 0; chk_err_exp = 0; to_exp = 0;
    chk_seen = 0; to_seen = 0;
  endtask

  initial begin
    int base;
    #3;
    check_reset_outputs("reset");
    check("reset_fifo_read", {63'd0, fifo_read}, 64'd0);
    cycles(2);
    resetn = 1'b1;
    ready_mode = 1;
    cycles(2);

    // Basic frame, garbage then SYNC-bearing payload, bad checksum then good.
    add_frame(32'h12345678, 1'b0);
    model_and_send();
    drain_and_check("basic");
    batch.push_back(8'h00); batch.push_back(8'hFF); batch.push_back(8'h3C);
    add_frame(32'hA5A50001, 1'b0);
    model_and_send();
    drain_and_check("garbage");
    batch.push_back(8'hA5); batch.push_back(8'h12); batch.push_back(8'h34);
    batch.push_back(8'h56); batch.push_back(8'h78); batch.push_back(8'h09);
    add_frame(32'hCAFE0003, 1'b0);
    model_and_send();
    drain_and_check("badchk");

    // Timeout after 16 idle ticks in PAYLOAD.
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h12);
    cycles(4);
    base = to_seen;
    repeat (TO - 1) pulse_tick();
    check("to_not_early", 64'(to_seen - base), 64'd0);
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    check("to_pulse", {63'd0, err_timeout}, 64'd1);
    to_exp++; bad_bump();
    cycles(1);
    check("to_pulse_end", {63'd0, err_timeout}, 64'd0);

    // A tick coinciding with a byte pop must not count.
    fifo_q.push_back(8'hA5);
    cycles(3);
    repeat (10) pulse_tick();
    fifo_q.push_back(8'h56);
    cycles(1);
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    cycles(1);
    base = to_seen;
    repeat (TO - 1) pulse_tick();
    check("to_coincident_cleared", 64'(to_seen - base), 64'd0);
    pulse_tick();
    check("to_coincident_fire", 64'(to_seen - base), 64'd1);
    to_exp++; bad_bump();
    add_frame(32'h0BADF00D, 1'b0);
    model_and_send();
    drain_and_check("timeout");

    // Backpressure: two frames queued with ready low.
    ready_mode = 0;
    add_frame(32'h11112222, 1'b0);
    add_frame(32'h33334444, 1'b0);
    model_and_send();
    cycles(50);
    check("bp_valid", {63'd0, cmd_valid}, 64'd1);
    check("bp_data", {32'd0, cmd_data}, 64'h11112222);
    check("bp_fifo_not_empty", {63'd0, fifo_empty}, 64'd0);
    ready_mode = 1;
    drain_and_check("backpressure");

    // Reset mid-frame.
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h12); fifo_q.push_back(8'h34);
    cycles(5);
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    clear_model();
    cycles(1);
    resetn = 1'b1;
    cycles(1);
    add_frame(32'h600DF00D, 1'b0);
    model_and_send();
    drain_and_check("after_rst_mid");

    // Reset during HOLD.
    ready_mode = 0;
    add_frame(32'hDEADBEEF, 1'b0);
    model_and_send();
    begin
      int n = 0;
      while (!cmd_valid && n < 50) begin
        cycles(1);
        n++;
      end
    end
    check("hold_before_rst", {63'd0, cmd_valid}, 64'd1);
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_hold");
    clear_model();
    cycles(1);
    resetn = 1'b1;
    ready_mode = 1;
    cycles(1);
    add_frame(32'h01020304, 1'b0);
    model_and_send();
    drain_and_check("after_rst_hold");

    // Randomized traffic with FIFO stalls and random ready.
    stall_mode = 1;
    ready_mode = 2;
    for (int s = 0; s < 60; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        for (int g = 0; g < $urandom_range(1, 4); g++) batch.push_back(rand_garbage());
      end else begin
        add_frame({rand_byte(), rand_byte(), rand_byte(), rand_byte()}, r < 4);
      end
      model_and_send();
      cycles($urandom_range(0, 6));
    end
    drain_and_check("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_framer.md
# cmd_framer

Framed command parser between the host UART receive FIFO and the command-execution state machine. Pops bytes from the FIFO and hunts for a sync byte. Collects a 4-byte big-endian payload and verifies an XOR checksum, then presents the 32-bit command (`{count[15:0], value[15:0]}`) on a valid/ready handshake. Replaces raw 4-byte assembly so a dropped or spurious UART byte cannot permanently misalign the command stream.

## Interface
- `SYNC`, default `8'hA5`: frame start byte.
- `TIMEOUT_TICKS`, default `16`: `tick` pulses allowed between bytes inside a frame before the frame is abandoned; legal range 1..255.
- `clk` in, 1: system clock (40 MHz).
- `resetn` in, 1: asynchronous, active-low reset.
- `tick` in, 1: single-cycle timebase strobe (~102 µs).
- `fifo_empty` in, 1: FIFO has no data; `fifo_data` is valid whenever this is low.
- `fifo_data` in, 8: head-of-FIFO byte (first-word-fall-through).
- `fifo_read` out, 1: pop strobe; the byte on `fifo_data` is consumed in the same cycle.
- `cmd_valid` out, 1: `cmd_data` holds a verified command.
- `cmd_ready` in, 1: consumer accepts the command.
- `cmd_data` out, 32: payload bytes B0..B3, with B0 in bits [31:24].
- `err_chk` out, 1: one-cycle pulse on checksum failure.
- `err_timeout` out, 1: one-cycle pulse on inter-byte timeout.
- `frames_ok` out, 16: count of accepted frames; wraps.
- `frames_bad` out, 8: count of checksum failures plus timeouts; saturates at 255.

## Operation
- Frame format: SYNC, B0, B1, B2, B3, CHK, where CHK = B0^B1^B2^B3.
- `fifo_read` is combinational: `!fifo_empty && state ∈ {HUNT, PAYLOAD, CHECK}`. It is never asserted in HOLD.
- States:
  - HUNT: consume bytes. A byte equal to SYNC → PAYLOAD with idx=0 and chk=0. Any other byte is discarded silently.
  - PAYLOAD: each consumed byte shifts into the data shift register and XORs into chk. idx increments; after idx=3 is consumed → CHECK. A SYNC value inside the payload is ordinary data.
  - CHECK: consume one byte.
    - If it equals chk: load `cmd_data`, set `cmd_valid`, increment `frames_ok` → HOLD.
    - Otherwise: pulse `err_chk`, increment `frames_bad` → HUNT.
  - HOLD: `cmd_valid` is high and `cmd_data` is stable. When `cmd_valid && cmd_ready` → HUNT. No FIFO reads occur here, so the FIFO provides backpressure.
- Timeout: an 8-bit counter clears on every consumed byte and on entry to PAYLOAD. It increments on `tick` only in PAYLOAD and CHECK. Reaching TIMEOUT_TICKS → pulse `err_timeout`, increment `frames_bad`, go to HUNT. HUNT and HOLD never time out.
- Byte consumption and `tick` in the same cycle: the byte wins and the counter clears.
- Timeout and a checksum failure cannot coincide, because a consumed byte clears the counter. `frames_bad` increments by at most 1 per cycle.

## Timing
- Reset values: state HUNT, `cmd_valid`=0, `cmd_data`=0, `err_chk`=0, `err_timeout`=0, `frames_ok`=0, `frames_bad`=0, internal counters 0. `fifo_read`=0 follows from the reset state being HUNT with the FIFO empty.
- With a non-empty FIFO, up to one byte is consumed per cycle. With back-to-back bytes, a frame takes 6 cycles from the SYNC pop to the CHK pop.
- `cmd_valid` rises in the cycle after the CHK pop, and `frames_ok` updates in that same cycle.
- `cmd_valid` falls in the cycle after the handshake. The next HUNT pop can occur in that cycle.
- Minimum frame-to-frame throughput is 7 cycles with `cmd_ready` held high.
- Error pulses are exactly 1 cycle wide and are registered, appearing in the cycle after the cause.
- Asserting `resetn` low mid-frame or in HOLD immediately returns all state to the reset values. A partial frame is lost.

## Structure
- Shared package `ess_pkg`: `SYNC_DEFAULT` constant, `FRAME_PAYLOAD_BYTES=4`, and the state encoding `FR_HUNT`, `FR_PAYLOAD`, `FR_CHECK`, `FR_HOLD` as a 2-bit enum.
- One sub-module, `tick_timeout`: the clear/enable/`tick` counter with a terminal-count pulse output, parameterised by TIMEOUT_TICKS. It is reusable by the SPI link watchdog.
- Parser FSM, shift register, checksum and statistics counters stay in `cmd_framer`.

## Test plan
- Frame A5 12 34 56 78 08, `cmd_ready`=1 → `cmd_data`=32'h12345678, one `cmd_valid` cycle, `frames_ok`=1, no error pulses.
- Garbage 00 FF 3C, then a valid frame → the garbage is discarded and the command is accepted. A frame with payload A5 A5 00 01 and CHK 01 yields `cmd_data`=32'hA5A50001.
- Bad CHK (A5 12 34 56 78 09) → `err_chk` 1-cycle pulse, `frames_bad`=1, no `cmd_valid`; a following valid frame is accepted.
- A5 12, then 16 ticks with no bytes → `err_timeout` on the 16th tick, state HUNT. A `tick` coincident with a byte pop in PAYLOAD does not advance the counter.
- Two back-to-back frames with `cmd_ready`=0 for 50 cycles → the first is held stable, no `fifo_read` in HOLD, `fifo_empty` stays low. Releasing ready delivers both in order.
- `resetn` pulsed low after B1, and separately during HOLD → all outputs return to 0 asynchronously, and the next complete frame parses correctly.
